// File: rtl/waiter_pkg.sv
// waiter_pkg: shared types and constants for the waiter robot route controller.
//   state_type  - route FSM states. The encoding is also the value driven on
//                 the motor `direction` bus, so the codes are fixed explicitly.
//   TIME_FOR_2S - two seconds of travel at the 50 MHz system clock.
package waiter_pkg;

  typedef enum logic [2:0] {
    IDLE_BASE  = 3'b000,
    FORWARDS   = 3'b001,
    IDLE_TABLE = 3'b010,
    BACKWARDS  = 3'b011,
    STOP       = 3'b100
  } state_type;

  localparam int TIME_FOR_2S = 100000000;

endpackage

// File: rtl/waiter_route_fsm_distance_filter.sv
// distance_filter: keeps the last DIST_DEPTH ultrasonic samples and flags
// proximity only when every one of them is at or below TOO_CLOSE, so a single
// noisy short reading cannot stop or "arrive" the robot.
//   clk, reset  - clock and synchronous active-high reset
//   dist_valid  - one-cycle strobe, distance holds a new sample
//   distance    - ultrasonic distance sample
//   too_close   - all history entries <= TOO_CLOSE (combinational from history)
module distance_filter #(
  parameter int DIST_W     = 8,
  parameter int DIST_DEPTH = 2,
  parameter int TOO_CLOSE  = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dist_valid,
  input  logic [DIST_W-1:0] distance,
  output logic              too_close
);

  localparam logic [DIST_W-1:0] TOO_CLOSE_V = DIST_W'(TOO_CLOSE);

  logic [DIST_W-1:0] hist [DIST_DEPTH];

  // Reset to all-ones ("far away") so the flag starts deasserted.
  // Every strobe shifts, even if the value repeats the previous one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DIST_DEPTH; i++) hist[i] <= '1;
    end else if (dist_valid) begin
      hist[0] <= distance;
      for (int i = 1; i < DIST_DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  always_comb begin
    too_close = 1'b1;
    for (int i = 0; i < DIST_DEPTH; i++) begin
      if (hist[i] > TOO_CLOSE_V) too_close = 1'b0;
    end
  end

endmodule

// File: rtl/waiter_route_fsm.sv
// waiter_route_fsm: route controller for the waiter robot. It drives the base
// through table 1 .. NUM_TABLES and back to base, one leg per debounced
// whistle, pausing in STOP when an obstacle appears before MIN_TRAVEL cycles.
//   clk, reset          - clock and synchronous active-high reset
//   dist_valid          - one-cycle strobe for a new ultrasonic sample
//   distance            - ultrasonic distance
//   frequency_input     - dominant FFT frequency bin
//   threshold_frequency - whistle threshold (zero-extended)
//   direction           - current state register, fed to the motors
//   table_idx           - tables reached on this trip
//   too_close           - filtered proximity flag
//   stopped             - high while in STOP
//
// Handshake: dist_valid is a strobe with no back-pressure; each cycle it is
// high, distance is consumed on that clock edge.
module waiter_route_fsm
  import waiter_pkg::*;
#(
  parameter int DIST_W     = 8,
  parameter int FREQ_W     = 10,
  parameter int THR_W      = 5,
  parameter int TOO_CLOSE  = 30,
  parameter int DIST_DEPTH = 2,
  parameter int FREQ_HOLD  = 4,
  parameter int MIN_TRAVEL = TIME_FOR_2S,
  parameter int NUM_TABLES = 2,
  parameter int IDX_W      = $clog2(NUM_TABLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dist_valid,
  input  logic [DIST_W-1:0] distance,
  input  logic [FREQ_W-1:0] frequency_input,
  input  logic [THR_W-1:0]  threshold_frequency,
  output logic [2:0]        direction,
  output logic [IDX_W-1:0]  table_idx,
  output logic              too_close,
  output logic              stopped
);

  localparam int FCNT_W = $clog2(FREQ_HOLD + 1);
  localparam int TMR_W  = (MIN_TRAVEL > 0) ? $clog2(MIN_TRAVEL + 1) : 1;
  localparam logic [FCNT_W-1:0] FREQ_HOLD_V  = FCNT_W'(FREQ_HOLD);
  localparam logic [TMR_W-1:0]  MIN_TRAVEL_V = TMR_W'(MIN_TRAVEL);
  localparam logic [IDX_W-1:0]  NUM_TABLES_V = IDX_W'(NUM_TABLES);

  state_type          state_q, state_d;
  state_type          saved_q, saved_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FCNT_W-1:0]  freq_cnt;
  logic               arm;
  logic [TMR_W-1:0]   timer;
  logic [FREQ_W-1:0]  thr_ext;
  logic               above;
  logic               trigger;
  logic               trigger_taken;
  logic               arrived;

  distance_filter #(
    .DIST_W     (DIST_W),
    .DIST_DEPTH (DIST_DEPTH),
    .TOO_CLOSE  (TOO_CLOSE)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .dist_valid (dist_valid),
    .distance   (distance),
    .too_close  (too_close)
  );

  assign thr_ext = FREQ_W'(threshold_frequency);
  assign above   = frequency_input > thr_ext;
  assign trigger = (freq_cnt == FREQ_HOLD_V) && arm;
  assign arrived = too_close && (timer >= MIN_TRAVEL_V);

  // Whistle debounce. arm drops when a whistle is consumed and only comes
  // back once the tone goes away, so one long whistle moves exactly one leg.
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_cnt <= '0;
      arm      <= 1'b1;
    end else begin
      if (trigger_taken)            freq_cnt <= '0;
      else if (!above)              freq_cnt <= '0;
      else if (freq_cnt != FREQ_HOLD_V) freq_cnt <= freq_cnt + FCNT_W'(1);

      if (trigger_taken) arm <= 1'b0;
      else if (!above)   arm <= 1'b1;
    end
  end

  // Travel timer: runs while moving, freezes during an obstacle pause so the
  // leg resumes where it left off, and clears while parked.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else begin
      case (state_q)
        FORWARDS, BACKWARDS: if (timer != MIN_TRAVEL_V) timer <= timer + TMR_W'(1);
        STOP:                timer <= timer;
        default:             timer <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE_BASE;
      saved_q <= FORWARDS;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    idx_d         = idx_q;
    trigger_taken = 1'b0;
    case (state_q)
      IDLE_BASE: begin
        if (trigger) begin
          state_d       = FORWARDS;
          trigger_taken = 1'b1;
        end
      end
      IDLE_TABLE: begin
        if (trigger) begin
          trigger_taken = 1'b1;
          state_d       = (idx_q < NUM_TABLES_V) ? FORWARDS : BACKWARDS;
        end
      end
      FORWARDS: begin
        if (arrived) begin
          state_d = IDLE_TABLE;
          idx_d   = idx_q + IDX_W'(1);
        end else if (too_close) begin
          state_d = STOP;
          saved_d = FORWARDS;
        end
      end
      BACKWARDS: begin
        if (arrived) begin
          state_d = IDLE_BASE;
          idx_d   = '0;
        end else if (too_close) begin
          state_d = STOP;
          saved_d = BACKWARDS;
        end
      end
      STOP: begin
        if (!too_close) state_d = saved_q;
      end
      default: state_d = IDLE_BASE;
    endcase
  end

  assign direction = state_q;
  assign table_idx = idx_q;
  assign stopped   = (state_q == STOP);

endmodule

// File: tb/tb_waiter_route_fsm.sv
module tb_waiter_route_fsm;

  localparam int MIN_T  = 20;
  localparam int HOLD   = 3;
  localparam int NT     = 2;
  localparam int DEPTH  = 2;
  localparam int CLOSE  = 30;

  // bench-side state names (independent of the design package)
  localparam int S_BASE  = 0;
  localparam int S_FWD   = 1;
  localparam int S_TABLE = 2;
  localparam int S_BWD   = 3;
  localparam int S_STOP  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dist_valid = 1'b0;
  logic [7:0] distance = 8'd0;
  logic [9:0] frequency_input = 10'd0;
  logic [4:0] threshold_frequency = 5'd5;
  logic [2:0] direction;
  logic [1:0] table_idx;
  logic       too_close;
  logic       stopped;

  int n_checks = 0;
  int n_fail   = 0;

  waiter_route_fsm #(
    .DIST_W     (8),
    .FREQ_W     (10),
    .THR_W      (5),
    .TOO_CLOSE  (CLOSE),
    .DIST_DEPTH (DEPTH),
    .FREQ_HOLD  (HOLD),
    .MIN_TRAVEL (MIN_T),
    .NUM_TABLES (NT)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .dist_valid          (dist_valid),
    .distance            (distance),
    .frequency_input     (frequency_input),
    .threshold_frequency (threshold_frequency),
    .direction           (direction),
    .table_idx           (table_idx),
    .too_close           (too_close),
    .stopped             (stopped)
  );

  // clock / reset block
  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_st, m_idx, m_fcnt, m_arm, m_timer, m_saved;
  int m_hist[$];
  bit model_ok = 1'b0;

  function automatic int m_close();
    int c = 1;
    foreach (m_hist[i]) if (m_hist[i] > CLOSE) c = 0;
    return c;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_st = S_BASE; m_idx = 0; m_fcnt = 0; m_arm = 1; m_timer = 0; m_saved = S_FWD;
      m_hist = {};
      for (int i = 0; i < DEPTH; i++) m_hist.push_back(255);
      model_ok = 1'b1;
    end else if (model_ok) begin
      int close, above, trig, arrived, took, nst, nidx;
      close   = m_close();
      above   = (int'(frequency_input) > int'(threshold_frequency));
      trig    = (m_fcnt == HOLD) && (m_arm == 1);
      arrived = close && (m_timer >= MIN_T);
      took = 0; nst = m_st; nidx = m_idx;
      case (m_st)
        S_BASE:  if (trig) begin nst = S_FWD; took = 1; end
        S_TABLE: if (trig) begin took = 1; nst = (m_idx < NT) ? S_FWD : S_BWD; end
        S_FWD:   if (arrived) begin nst = S_TABLE; nidx = m_idx + 1; end
                 else if (close) begin nst = S_STOP; m_saved = S_FWD; end
        S_BWD:   if (arrived) begin nst = S_BASE; nidx = 0; end
                 else if (close) begin nst = S_STOP; m_saved = S_BWD; end
        default: if (!close) nst = m_saved;
      endcase
      if (m_st == S_FWD || m_st == S_BWD) m_timer = (m_timer < MIN_T) ? m_timer + 1 : MIN_T;
      else if (m_st != S_STOP) m_timer = 0;
      if (took) m_fcnt = 0;
      else if (above) m_fcnt = (m_fcnt < HOLD) ? m_fcnt + 1 : HOLD;
      else m_fcnt = 0;
      if (took) m_arm = 0;
      else if (!above) m_arm = 1;
      if (dist_valid) begin
        m_hist.push_front(int'(distance));
        void'(m_hist.pop_back());
      end
      m_st = nst; m_idx = nidx;
    end
  end

  // compare process: every cycle once the model has seen a reset edge
  always @(negedge clk) begin
    if (model_ok) begin
      check("direction", int'(direction), m_st);
      check("table_idx", int'(table_idx), m_idx);
      check("too_close", int'(too_close), m_close());
      check("stopped",   int'(stopped),   (m_st == S_STOP) ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample(input int d);
    dist_valid = 1'b1;
    distance   = 8'(d);
    tick(1);
    dist_valid = 1'b0;
    distance   = 8'($urandom_range(0, 255));
  endtask

  // whistle long enough for one trigger, then silence for one edge
  task automatic whistle();
    frequency_input = 10'd12;
    tick(HOLD + 1);
    frequency_input = 10'd0;
    tick(1);
  endtask

  task automatic clear_hist();
    sample(200);
    sample(200);
  endtask

  task automatic arrive_after(input int n);
    tick(n);
    sample(20);
    sample(20);
    tick(1);
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    check("reset_dir", int'(direction), 0);
    check("reset_idx", int'(table_idx), 0);
    check("reset_close", int'(too_close), 0);

    // trigger debounce: 2 cycles is not enough, 3 cycles fires on edge 4
    frequency_input = 10'd12;
    tick(2);
    frequency_input = 10'd0;
    tick(1);
    check("short_whistle", int'(direction), 0);
    frequency_input = 10'd12;
    tick(3);
    check("edge3_still_idle", int'(direction), 0);
    tick(1);
    check("edge4_forwards", int'(direction), 1);
    frequency_input = 10'd0;
    tick(1);

    // single short reading between far ones is filtered out
    sample(200);
    sample(10);
    check("single_close", int'(too_close), 0);
    sample(200);
    check("single_close_dir", int'(direction), 1);

    // full trip
    arrive_after(25);
    check("leg1_dir", int'(direction), 2);
    check("leg1_idx", int'(table_idx), 1);
    clear_hist();
    whistle();
    check("leg2_start", int'(direction), 1);
    arrive_after(25);
    check("leg2_dir", int'(direction), 2);
    check("leg2_idx", int'(table_idx), 2);
    clear_hist();
    whistle();
    check("leg3_start", int'(direction), 3);
    arrive_after(25);
    check("home_dir", int'(direction), 0);
    check("home_idx", int'(table_idx), 0);

    // obstacle pause early in a leg
    clear_hist();
    whistle();
    tick(2);
    sample(10);
    sample(10);
    tick(1);
    check("obst_stop", int'(direction), 4);
    check("obst_stopped", int'(stopped), 1);
    sample(200);
    tick(1);
    check("obst_resume", int'(direction), 1);
    arrive_after(20);
    check("obst_arrive", int'(direction), 2);

    // timer boundary: close at timer 19 pauses, resumed timer 20 arrives
    clear_hist();
    whistle();
    arrive_after(16);
    check("t19_stop", int'(direction), 4);
    sample(200);
    tick(1);
    check("t20_resume", int'(direction), 1);
    sample(20);
    sample(20);
    tick(1);
    check("t20_arrive", int'(direction), 2);
    check("t20_idx", int'(table_idx), 2);

    // back home, then rearm behaviour
    clear_hist();
    whistle();
    arrive_after(25);
    check("home2_dir", int'(direction), 0);
    clear_hist();
    frequency_input = 10'd12;
    tick(30);
    sample(20);
    sample(20);
    tick(66);
    check("rearm_one_leg", int'(direction), 2);
    check("rearm_idx", int'(table_idx), 1);
    frequency_input = 10'd0;
    clear_hist();
    frequency_input = 10'd12;
    tick(3);
    check("rearm_edge3", int'(direction), 2);
    tick(1);
    check("rearm_edge4", int'(direction), 1);
    frequency_input = 10'd0;

    // reset mid-leg in BACKWARDS with table_idx 2
    arrive_after(25);
    clear_hist();
    whistle();
    check("pre_reset_dir", int'(direction), 3);
    check("pre_reset_idx", int'(table_idx), 2);
    reset = 1'b1;
    tick(1);
    check("midreset_dir", int'(direction), 0);
    check("midreset_idx", int'(table_idx), 0);
    check("midreset_close", int'(too_close), 0);
    reset = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
